alu_unit: RTL and testbench

- Registered integer ALU for the datapath execute stage.
- Operates on two WIDTH-bit operands under a 4-bit opcode.
- Arithmetic, shift and logic results appear on ALUResult.
- Unsigned and signed magnitude comparison results appear on a one-hot greater/equal/smaller flag vector (GES).
- One-cycle latency. Downstream logic samples the outputs on the cycle after the operands are presented.

---
 rtl/alu_unit_if.sv | 38 +++
 rtl/alu_unit.sv | 118 +++++++++++
 tb/tb_alu_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - operand/opcode and result bundle for alu_unit
//
// Ports (via modports):
//   master : drives in_valid, Arg1, Arg2, ALU_Control; receives out_valid, ALUResult, GES
//   slave  : the ALU side, mirror image of master
// Optional macro ALU_ZERO_FLAG_EN adds the Zero result flag to the bundle.
interface alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] Arg1;
    logic [WIDTH-1:0] Arg2;
    logic [3:0]       ALU_Control;
    logic             out_valid;
    logic [WIDTH-1:0] ALUResult;
    logic [2:0]       GES;
`ifdef ALU_ZERO_FLAG_EN
    logic             Zero;

    modport master (
        output in_valid, Arg1, Arg2, ALU_Control,
        input  out_valid, ALUResult, GES, Zero
    );
    modport slave (
        input  in_valid, Arg1, Arg2, ALU_Control,
        output out_valid, ALUResult, GES, Zero
    );
`else
    modport master (
        output in_valid, Arg1, Arg2, ALU_Control,
        input  out_valid, ALUResult, GES
    );
    modport slave (
        input  in_valid, Arg1, Arg2, ALU_Control,
        output out_valid, ALUResult, GES
    );
`endif
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered integer ALU with one-hot compare flags, one-cycle latency
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_unit_if.slave
//           in_valid, Arg1, Arg2, ALU_Control  -> operation request
//           out_valid, ALUResult, GES[2:0]     <- registered result (GES = greater/equal/smaller)
// Optional macro ALU_ZERO_FLAG_EN adds bus.Zero, registered alongside ALUResult.
// WIDTH must match the WIDTH the interface instance was built with.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_CMPU = 4'b1000;
    localparam logic [3:0] OP_CMPS = 4'b1001;

    localparam logic [2:0] GES_GT = 3'b100;
    localparam logic [2:0] GES_EQ = 3'b010;
    localparam logic [2:0] GES_LT = 3'b001;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_d;
    logic [2:0]       ges_d;
    logic             is_cmp;
    logic             is_arith;

    // Only the low SHW bits of Arg2 form the shift amount; upper bits are ignored.
    assign shamt    = bus.Arg2[SHW-1:0];
    assign is_cmp   = (bus.ALU_Control == OP_CMPU) || (bus.ALU_Control == OP_CMPS);
    assign is_arith = ~bus.ALU_Control[3];

    always_comb begin
        res_d = '0;
        ges_d = 3'b000;
        case (bus.ALU_Control)
            OP_ADD: res_d = bus.Arg1 + bus.Arg2;
            OP_SUB: res_d = bus.Arg1 - bus.Arg2;
            OP_SRL: res_d = bus.Arg1 >> shamt;
            OP_SRA: res_d = $unsigned($signed(bus.Arg1) >>> shamt);
            OP_SLL: res_d = bus.Arg1 << shamt;
            OP_XOR: res_d = bus.Arg1 ^ bus.Arg2;
            OP_OR:  res_d = bus.Arg1 | bus.Arg2;
            OP_AND: res_d = bus.Arg1 & bus.Arg2;
            OP_CMPU: begin
                if (bus.Arg1 > bus.Arg2)
                    ges_d = GES_GT;
                else if (bus.Arg1 == bus.Arg2)
                    ges_d = GES_EQ;
                else
                    ges_d = GES_LT;
            end
            OP_CMPS: begin
                if ($signed(bus.Arg1) > $signed(bus.Arg2))
                    ges_d = GES_GT;
                else if (bus.Arg1 == bus.Arg2)
                    ges_d = GES_EQ;
                else
                    ges_d = GES_LT;
            end
            default: begin
                res_d = '0;
                ges_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.ALUResult <= '0;
            bus.GES       <= 3'b000;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.ALUResult <= res_d;
                bus.GES       <= ges_d;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic zero_d;

    // Compare ops report equality; reserved opcodes never assert Zero.
    always_comb begin
        zero_d = 1'b0;
        if (is_arith)
            zero_d = (res_d == '0);
        else if (is_cmp)
            zero_d = (ges_d == GES_EQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.Zero <= 1'b0;
        else if (bus.in_valid)
            bus.Zero <= zero_d;
    end
`else
    logic unused_flags;
    assign unused_flags = is_cmp ^ is_arith;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit with a behavioural reference model
module tb_alu_unit;
    localparam int WIDTH = 32;
    localparam int N_PER_OP = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: what the outputs must show after the latest edge
    logic [WIDTH-1:0] m_res;
    logic [2:0]       m_ges;
    logic             m_valid;
    logic             m_zero;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [2:0] g, output logic z);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        g = 3'b000;
        case (op)
            4'd0: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd1: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'd2: r = 32'(64'(a) / (64'd1 << sh));
            4'd3: r = 32'(sa >>> sh);
            4'd4: r = 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd5: r = a ^ b;
            4'd6: r = a | b;
            4'd7: r = a & b;
            4'd8: g = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
            4'd9: g = (sa > sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
            default: ;
        endcase
        if (op <= 4'd7)
            z = (r == 0);
        else if (op <= 4'd9)
            z = (g == 3'b010);
        else
            z = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   <= '0;
            m_ges   <= 3'b000;
            m_valid <= 1'b0;
            m_zero  <= 1'b0;
        end else begin
            m_valid <= bus.in_valid;
            if (bus.in_valid) begin
                logic [31:0] r;
                logic [2:0]  g;
                logic        z;
                model_op(bus.ALU_Control, bus.Arg1, bus.Arg2, r, g, z);
                m_res  <= r;
                m_ges  <= g;
                m_zero <= z;
            end
        end
    end

    // continuous compare against the model on every falling edge once out of reset
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            check("ALUResult", 64'(bus.ALUResult), 64'(m_res));
            check("GES", 64'(bus.GES), 64'(m_ges));
`ifdef ALU_ZERO_FLAG_EN
            check("Zero", 64'(bus.Zero), 64'(m_zero));
`endif
        end
    end

    task automatic apply(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid    = v;
        bus.ALU_Control = op;
        bus.Arg1        = a;
        bus.Arg2        = b;
    endtask

    // literal expectation for the op applied by the previous apply()
    task automatic expect_out(input string name, input logic [31:0] r, input logic [2:0] g);
        @(negedge clk);
        check({name, ".res"}, 64'(bus.ALUResult), 64'(r));
        check({name, ".ges"}, 64'(bus.GES), 64'(g));
        check({name, ".vld"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic op_lit(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic [2:0] g);
        apply(1'b1, op, a, b);
        expect_out(name, r, g);
    endtask

    initial begin
        logic [31:0] hold_res;
        logic [2:0]  hold_ges;
        bus.in_valid    = 1'b0;
        bus.ALU_Control = 4'd0;
        bus.Arg1        = '0;
        bus.Arg2        = '0;
        #12;
        check("rst.res", 64'(bus.ALUResult), 64'd0);
        check("rst.ges", 64'(bus.GES), 64'd0);
        check("rst.vld", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // reset mid-stream, asserted between clock edges
        op_lit("add5_7", 4'd0, 32'd5, 32'd7, 32'd12, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        check("arst.res", 64'(bus.ALUResult), 64'd0);
        check("arst.ges", 64'(bus.GES), 64'd0);
        check("arst.vld", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        op_lit("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b000);
        op_lit("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 3'b000);
        op_lit("srl4", 4'd2, 32'h8000_00F0, 32'h24, 32'h0800_000F, 3'b000);
        op_lit("sra4", 4'd3, 32'h8000_00F0, 32'h24, 32'hF800_000F, 3'b000);
        op_lit("sll4", 4'd4, 32'h8000_00F0, 32'h24, 32'h0000_0F00, 3'b000);
        op_lit("srl0", 4'd2, 32'h8000_00F0, 32'h20, 32'h8000_00F0, 3'b000);
        op_lit("sra0", 4'd3, 32'h8000_00F0, 32'h20, 32'h8000_00F0, 3'b000);
        op_lit("sll0", 4'd4, 32'h8000_00F0, 32'h20, 32'h8000_00F0, 3'b000);
        op_lit("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 3'b000);
        op_lit("or", 4'd6, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 3'b000);
        op_lit("and", 4'd7, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 3'b000);
        op_lit("cmpu_gt", 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b100);
        op_lit("cmps_lt", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 3'b001);
        op_lit("cmpu_eq", 4'd8, 32'h1234_5678, 32'h1234_5678, 32'h0, 3'b010);
        op_lit("cmps_eq", 4'd9, 32'h1234_5678, 32'h1234_5678, 32'h0, 3'b010);

        // hold for three idle cycles
        op_lit("pre_hold", 4'd0, 32'h1111_0000, 32'h0000_2222, 32'h1111_2222, 3'b000);
        hold_res = 32'h1111_2222;
        hold_ges = 3'b000;
        apply(1'b0, 4'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.res", 64'(bus.ALUResult), 64'(hold_res));
            check("hold.ges", 64'(bus.GES), 64'(hold_ges));
            check("hold.vld", 64'(bus.out_valid), 64'd0);
        end
        op_lit("reserved", 4'b1100, 32'hABCD_EF01, 32'h2345_6789, 32'h0, 3'b000);

        // randomized sweep, every opcode, occasional idle cycles and corner operands
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < N_PER_OP; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 7))
                    0: b = a;
                    1: a = 32'hFFFF_FFFF;
                    2: b = 32'h8000_0000;
                    3: a = 32'h0;
                    default: ;
                endcase
                apply(($urandom_range(0, 7) != 0), 4'(op), a, b);
            end
        end
        apply(1'b0, 4'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
